bp_wb_ctrl: RTL and testbench

- Write-back sequencer directly downstream of the bit-parallel DSP core output buffers.
- Walks one ping-pong output-buffer bank address by address, issuing two column-group reads per address.
- Captures the core's registered 128-bit write-back word, and streams it out on an AXI4-Stream master with full backpressure support.
- Credit-based issue plus a small output FIFO hide the core's fixed read latency.

---
 rtl/bp_wb_ctrl.sv | 132 +++++++++++++
 tb/tb_bp_wb_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bp_wb_ctrl.sv
// Write-back sequencer: walks one output-buffer bank, issues two column-group
// reads per address under a credit limit, and streams the words out on AXI4-Stream.
module bp_wb_ctrl #(
  parameter int BP_COLS          = 18,
  parameter int BP_OUT_BUF_DEPTH = 9,
  parameter int RD_LAT           = 2,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [BP_OUT_BUF_DEPTH-1:0]           num_rows,
  input  logic                                  bank_sel,
  output logic                                  busy,
  output logic                                  done,
  output logic [2:0]                            bp_out_buf_wb_en,
  output logic [BP_COLS*BP_OUT_BUF_DEPTH-1:0]   bp_out_buf_wb_addr,
  output logic                                  bp_out_buf_wb_sel,
  input  logic [127:0]                          bp_out_wb_data,
  output logic [127:0]                          m_axis_wb_tdata,
  output logic                                  m_axis_wb_tvalid,
  input  logic                                  m_axis_wb_tready,
  output logic                                  m_axis_wb_tlast
);

  localparam int DATA_W = 128;
  localparam int AW     = BP_OUT_BUF_DEPTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     rows, addr_cnt;
  logic              grp;
  logic [CNT_W-1:0]  fifo_count, inflight;
  logic [CNT_W:0]    credit_used;
  logic              issue, last_issue, push, push_last, pop, head_last;
  logic [RD_LAT-1:0] vld_p, last_p;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];

  // Issue stage: a read goes out only if its word is guaranteed a FIFO slot on arrival.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue       = (state == ISSUE) && (credit_used < DEPTH_C);
  assign last_issue  = grp && (addr_cnt == rows - AW'(1));

  assign bp_out_buf_wb_en   = {2'b00, grp};
  assign bp_out_buf_wb_addr = {BP_COLS{addr_cnt}};

  // Arrival stage: end of the read-latency delay line writes the FIFO.
  assign push      = vld_p[RD_LAT-1];
  assign push_last = last_p[RD_LAT-1];

  // Output stage
  assign head_last        = fifo_last[rd_ptr];
  assign m_axis_wb_tvalid = (fifo_count != '0);
  assign m_axis_wb_tdata  = m_axis_wb_tvalid ? fifo_data[rd_ptr] : '0;
  assign m_axis_wb_tlast  = m_axis_wb_tvalid & head_last;
  assign pop              = m_axis_wb_tvalid & m_axis_wb_tready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (num_rows == '0) ? DONE : ISSUE;
      ISSUE: if (issue && last_issue) state_nxt = DRAIN;
      DRAIN: if (pop && head_last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      rows              <= '0;
      addr_cnt          <= '0;
      grp               <= 1'b0;
      bp_out_buf_wb_sel <= 1'b0;
      vld_p             <= '0;
      inflight          <= '0;
      fifo_count        <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == DONE);
      if (state == IDLE && start) begin
        rows              <= num_rows;
        bp_out_buf_wb_sel <= bank_sel;
        addr_cnt          <= '0;
        grp               <= 1'b0;
        busy              <= 1'b1;
      end else if (state == DONE) begin
        busy <= 1'b0;
      end
      // The final issue leaves the counters parked so wb_en/wb_addr hold.
      if (issue && !last_issue) begin
        grp <= ~grp;
        if (grp) addr_cnt <= addr_cnt + AW'(1);
      end
      vld_p[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      case ({issue, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    last_p[0] <= issue & last_issue;
    for (int i = 1; i < RD_LAT; i++) last_p[i] <= last_p[i-1];
    if (push) begin
      fifo_data[wr_ptr] <= bp_out_wb_data;
      fifo_last[wr_ptr] <= push_last;
    end
  end

endmodule

// File: tb/tb_bp_wb_ctrl.sv
// Directed bench for bp_wb_ctrl: table of bank-drain runs against a two-stage core
// read model, plus hand-written reset-mid-stream sequence.
module tb_bp_wb_ctrl;

  localparam int BP_COLS = 18;
  localparam int AW      = 9;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start, bank_sel, busy, done;
  logic [AW-1:0]           num_rows;
  logic [2:0]              wb_en;
  logic [BP_COLS*AW-1:0]   wb_addr;
  logic                    wb_sel;
  logic [127:0]            core_data, tdata;
  logic                    tvalid, tready, tlast;

  int n_vec = 0;
  int n_err = 0;

  bp_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .bank_sel(bank_sel),
    .busy(busy), .done(done), .bp_out_buf_wb_en(wb_en), .bp_out_buf_wb_addr(wb_addr),
    .bp_out_buf_wb_sel(wb_sel), .bp_out_wb_data(core_data), .m_axis_wb_tdata(tdata),
    .m_axis_wb_tvalid(tvalid), .m_axis_wb_tready(tready), .m_axis_wb_tlast(tlast)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic sel, input logic [2:0] en, input logic [AW-1:0] a);
    mk = {32'(sel) << 28 | 32'(en) << 16 | 32'(a),
          32'h0BAD_F00D + 32'(a) * 7,
          32'hC0DE_0000 | 32'(en),
          ~32'(a)};
  endfunction

  // Core read path: address register, then registered output word.
  logic [AW-1:0] c_addr;
  logic [2:0]    c_en;
  logic          c_sel;
  always @(posedge clk) begin
    c_addr    <= wb_addr[BP_COLS*AW-1 -: AW];
    c_en      <= wb_en;
    c_sel     <= wb_sel;
    core_data <= mk(c_sel, c_en, c_addr);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int   rows;
    logic bank;
    int   mode;      // 0: ready always, 1: ready pattern 1-0-0-1, 2: ready low 20 cycles
    int   inj;       // cycle of an extra start while busy, -1 none
    int   exp_first; // cycle of first beat, -1 don't care
    int   exp_done;  // cycle of done pulse, -1 don't care
    int   exp_max;   // exact peak fifo+inflight, -1 only bounded by 4
  } vec_t;

  task automatic run(input vec_t v, input string nm);
    int beats, first_k, done_k, busy_n, max_occ, occ;
    logic [127:0] prev_data;
    logic prev_stall, prev_last;
    beats = 0; first_k = -1; done_k = -1; busy_n = 0; max_occ = 0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    for (int k = 0; k < 400 && done_k < 0; k++) begin
      @(posedge clk); #1;
      start    = (k == 0) || (k == v.inj);
      num_rows = (k == 0) ? AW'(v.rows) : AW'(7);
      bank_sel = (k == 0) ? v.bank : ~v.bank;
      case (v.mode)
        0:       tready = 1'b1;
        1:       tready = (k % 4 == 0) || (k % 4 == 3);
        default: tready = (k >= 20);
      endcase
      @(negedge clk);
      occ = int'(dut.fifo_count) + int'(dut.inflight);
      if (occ > max_occ) max_occ = occ;
      if (busy) busy_n++;
      if (prev_stall)
        chk({nm, " stall-stable"}, {tvalid, tlast, tdata}, {1'b1, prev_last, prev_data});
      if (v.mode == 2 && k == 19)
        chk({nm, " stalled-fill"}, {int'(dut.fifo_count), int'(dut.inflight), beats}, {32'd4, 32'd0, 32'd0});
      if (tvalid && tready) begin
        if (first_k < 0) first_k = k;
        chk($sformatf("%s beat%0d data", nm, beats), tdata,
            mk(v.bank, 3'(beats % 2), AW'(beats / 2)));
        chk($sformatf("%s beat%0d last", nm, beats), tlast, (beats == 2 * v.rows - 1));
        beats++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      if (done) done_k = k;
    end
    if (done_k < 0) $display("FAIL %s timeout: no done within 400 cycles", nm);
    @(posedge clk); #1;
    start = 1'b0; tready = 1'b1;
    @(negedge clk);
    chk({nm, " done-pulse-end"}, {done, busy, tvalid}, 3'b000);
    chk({nm, " beats"}, beats, 2 * v.rows);
    chk({nm, " busy-len"}, busy_n, done_k - 1);
    chk({nm, " credit-bound"}, (max_occ <= 4), 1'b1);
    if (v.exp_first >= 0) chk({nm, " first-beat"}, first_k, v.exp_first);
    if (v.exp_done >= 0)  chk({nm, " done-cycle"}, done_k, v.exp_done);
    if (v.exp_max >= 0)   chk({nm, " peak-occ"}, max_occ, v.exp_max);
  endtask

  vec_t vt [5];
  vec_t vr;
  int   seen;

  initial begin
    vt[0] = '{3, 1'b1, 0, -1, 4, 11, -1};
    vt[1] = '{0, 1'b0, 0, -1, -1, 2, 0};
    vt[2] = '{8, 1'b0, 1, -1, -1, -1, -1};
    vt[3] = '{5, 1'b1, 2, -1, 20, -1, 4};
    vt[4] = '{3, 1'b0, 0, 3, 4, 11, -1};
    vr    = '{4, 1'b0, 0, -1, 4, 13, -1};

    rst_n = 1'b0; start = 1'b0; tready = 1'b0; num_rows = '0; bank_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ctrl", {busy, done, tvalid, tlast, wb_sel, wb_en}, '0);
    chk("reset addr", wb_addr, '0);
    chk("reset data", tdata, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run(vt[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a 4-row drain, right after beat 3.
    seen = 0;
    @(posedge clk); #1;
    start = 1'b1; num_rows = AW'(4); bank_sel = 1'b1; tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 30 && seen < 3; k++) begin
      @(negedge clk);
      if (tvalid && tready) seen++;
    end
    chk("midrst beats-before", seen, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst ctrl", {busy, done, tvalid, tlast, wb_sel, wb_en}, '0);
    chk("midrst addr", wb_addr, '0);
    chk("midrst data", tdata, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst no-done", {done, tvalid}, 2'b00);
    end
    rst_n = 1'b1;
    run(vr, "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
